int_priority_controller: RTL and testbench

Collects one-cycle interrupt request pulses from the external interrupt handlers and latches them as pending. Selects the highest-priority enabled pending source and presents it to the CPU core over a valid/ack handshake. Tracks in-service sources until the core signals end-of-interrupt. Sits between the per-pin edge detectors and the core's trap/interrupt entry logic.

---
 rtl/int_ctrl_pkg.sv | 31 +++
 rtl/int_priority_controller_prio_encoder.sv | 23 ++
 rtl/int_priority_controller.sv | 111 +++++++++++
 tb/tb_int_priority_controller.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared types and helpers for the interrupt priority controller.
// Holds the FSM state enum, the default source count and a lowest-set-bit helper.
package int_ctrl_pkg;

  localparam int DEFAULT_NUM_SOURCES = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } prio_result_t;

  // Lowest index wins, matching "index 0 is highest priority".
  function automatic prio_result_t lowest_set(input logic [31:0] vec);
    prio_result_t res;
    res.found = 1'b0;
    res.idx   = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) begin
        res.found = 1'b1;
        res.idx   = 5'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/int_priority_controller_prio_encoder.sv
// Parameterized lowest-index-first priority encoder.
// Used both for candidate selection and for finding the top in-service source.
module prio_encoder #(
  parameter int WIDTH = 4,
  parameter int ID_W  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_priority_controller.sv
// Interrupt priority controller: latches request pulses, presents the best source over valid/ack.
// Define INT_CTRL_NESTING_EN to let higher-priority sources preempt ones already in service.
module int_priority_controller
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SOURCES = DEFAULT_NUM_SOURCES,
  parameter int ID_W        = $clog2(NUM_SOURCES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SOURCES-1:0] int_req,
  input  logic [NUM_SOURCES-1:0] int_mask,
  input  logic                   global_int_en,
  output logic                   irq_valid,
  output logic [ID_W-1:0]        irq_id,
  input  logic                   irq_ack,
  input  logic                   irq_eoi,
  output logic [NUM_SOURCES-1:0] pending,
  output logic [NUM_SOURCES-1:0] in_service
);

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        irq_id_q, irq_id_d;
  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [NUM_SOURCES-1:0] in_service_q, in_service_d;

  logic                   cand_found;
  logic [ID_W-1:0]        cand_id;
  logic                   isr_found;
  logic [ID_W-1:0]        isr_id;
  logic                   eligible;
  logic                   accept;
  logic [NUM_SOURCES-1:0] accept_mask;

  prio_encoder #(.WIDTH(NUM_SOURCES), .ID_W(ID_W)) u_cand_enc (
    .vec   (pending_q & int_mask),
    .found (cand_found),
    .idx   (cand_id)
  );

  prio_encoder #(.WIDTH(NUM_SOURCES), .ID_W(ID_W)) u_isr_enc (
    .vec   (in_service_q),
    .found (isr_found),
    .idx   (isr_id)
  );

`ifdef INT_CTRL_NESTING_EN
  assign eligible = global_int_en & cand_found & (~isr_found | (cand_id < isr_id));
`else
  assign eligible = global_int_en & cand_found & ~isr_found;
`endif

  assign accept      = (state_q == REQ) & irq_ack;
  assign accept_mask = accept ? (NUM_SOURCES'(1) << irq_id_q) : '0;

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    case (state_q)
      IDLE: begin
        if (eligible) begin
          state_d  = REQ;
          irq_id_d = cand_id;
        end
      end
      REQ: begin
        // Acceptance beats withdrawal when both happen together.
        if (irq_ack) begin
          state_d = IDLE;
        end else if (!global_int_en || !int_mask[irq_id_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh request in the acceptance cycle is a new event, so the set wins over the clear.
  always_comb begin
    pending_d = (pending_q & ~accept_mask) | int_req;
  end

  // EOI retires against the pre-ack value; the ack bit is then OR'd in.
  always_comb begin
    in_service_d = in_service_q;
    if (irq_eoi && isr_found) begin
      in_service_d[isr_id] = 1'b0;
    end
    in_service_d = in_service_d | accept_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      irq_id_q     <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
    end else begin
      state_q      <= state_d;
      irq_id_q     <= irq_id_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
    end
  end

  assign irq_valid  = (state_q == REQ);
  assign irq_id     = irq_id_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_int_priority_controller.sv
// Scoreboard testbench for int_priority_controller.
// Expected IDs are queued when requests are driven and popped when irq_valid appears.
module tb_int_priority_controller;

  localparam int NS = 4;

  logic          clk;
  logic          rst;
  logic [NS-1:0] int_req;
  logic [NS-1:0] int_mask;
  logic          global_int_en;
  logic          irq_valid;
  logic [1:0]    irq_id;
  logic          irq_ack;
  logic          irq_eoi;
  logic [NS-1:0] pending;
  logic [NS-1:0] in_service;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  int_priority_controller dut (
    .clk           (clk),
    .rst           (rst),
    .int_req       (int_req),
    .int_mask      (int_mask),
    .global_int_en (global_int_en),
    .irq_valid     (irq_valid),
    .irq_id        (irq_id),
    .irq_ack       (irq_ack),
    .irq_eoi       (irq_eoi),
    .pending       (pending),
    .in_service    (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic [NS-1:0] v);
    int_req = v;
    tick();
    int_req = '0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
  endtask

  // Waits a bounded number of cycles for irq_valid, popping the scoreboard entry if it appears.
  task automatic next_irq(input int max_cycles, output bit got, output logic [1:0] id,
                          output logic [1:0] exp);
    int n;
    got = 1'b0;
    id  = 'x;
    exp = 'x;
    n   = 0;
    while (!got && n <= max_cycles) begin
      if (irq_valid === 1'b1) begin
        got = 1'b1;
        id  = irq_id;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
      end else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (irq_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", irq_valid); end
    checks++;
    if (irq_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_id: got %0d want 0", irq_id); end
    checks++;
    if (pending !== 4'b0000) begin errors++; $display("[TB] FAIL reset_pending: got %b want 0000", pending); end
    checks++;
    if (in_service !== 4'b0000) begin errors++; $display("[TB] FAIL reset_in_service: got %b want 0000", in_service); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bit got; logic [1:0] id, exp;
    exp_q.push_back(2'd2);
    pulse_req(4'b0100);
    checks++;
    if (pending !== 4'b0100 || irq_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_t1: pending=%b valid=%b want 0100/0", pending, irq_valid);
    end
    tick();
    checks++;
    if (irq_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_latency: valid=%b want 1", irq_valid); end
    next_irq(0, got, id, exp);
    checks++;
    if (!got || id !== exp) begin errors++; $display("[TB] FAIL single_id: got %0d want %0d", id, exp); end
    pulse_ack();
    checks++;
    if (irq_valid !== 1'b0 || in_service !== 4'b0100 || pending !== 4'b0000) begin
      errors++; $display("[TB] FAIL single_ack: valid=%b ins=%b pend=%b want 0/0100/0000", irq_valid, in_service, pending);
    end
    pulse_eoi();
    checks++;
    if (in_service !== 4'b0000) begin errors++; $display("[TB] FAIL single_eoi: got %b want 0000", in_service); end
  endtask

  task automatic test_priority();
    bit got; logic [1:0] id, exp;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    pulse_req(4'b1010);
    next_irq(3, got, id, exp);
    checks++;
    if (!got || id !== exp) begin errors++; $display("[TB] FAIL prio_first: got %0d want %0d", id, exp); end
    pulse_ack();
    pulse_eoi();
    next_irq(3, got, id, exp);
    checks++;
    if (!got || id !== exp) begin errors++; $display("[TB] FAIL prio_second: got %0d want %0d", id, exp); end
    exp_q.push_back(2'd0);
    pulse_req(4'b0001);
    tick();
    checks++;
    if (irq_valid !== 1'b1 || irq_id !== 2'd3) begin
      errors++; $display("[TB] FAIL prio_hold: valid=%b id=%0d want 1/3", irq_valid, irq_id);
    end
    pulse_ack();
    pulse_eoi();
    next_irq(3, got, id, exp);
    checks++;
    if (!got || id !== exp) begin errors++; $display("[TB] FAIL prio_late: got %0d want %0d", id, exp); end
    pulse_ack();
    pulse_eoi();
  endtask

  task automatic test_masking();
    bit got; logic [1:0] id, exp;
    int_mask = 4'b0111;
    pulse_req(4'b1000);
    tick();
    tick();
    checks++;
    if (pending[3] !== 1'b1 || irq_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL mask_block: pend3=%b valid=%b want 1/0", pending[3], irq_valid);
    end
    exp_q.push_back(2'd0);
    pulse_req(4'b0001);
    next_irq(3, got, id, exp);
    checks++;
    if (!got || id !== exp) begin errors++; $display("[TB] FAIL mask_id0: got %0d want %0d", id, exp); end
    global_int_en = 1'b0;
    tick();
    checks++;
    if (irq_valid !== 1'b0 || pending[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL withdraw: valid=%b pend0=%b want 0/1", irq_valid, pending[0]);
    end
    exp_q.push_back(2'd0);
    global_int_en = 1'b1;
    next_irq(3, got, id, exp);
    checks++;
    if (!got || id !== exp) begin errors++; $display("[TB] FAIL reassert: got %0d want %0d", id, exp); end
    pulse_ack();
    pulse_eoi();
    exp_q.push_back(2'd3);
    int_mask = 4'b1111;
    next_irq(3, got, id, exp);
    checks++;
    if (!got || id !== exp) begin errors++; $display("[TB] FAIL unmask: got %0d want %0d", id, exp); end
    pulse_ack();
    pulse_eoi();
  endtask

  task automatic test_back_to_back();
    bit got; logic [1:0] id, exp;
    exp_q.push_back(2'd2);
    pulse_req(4'b0100);
    next_irq(3, got, id, exp);
    checks++;
    if (!got || id !== exp) begin errors++; $display("[TB] FAIL b2b_id: got %0d want %0d", id, exp); end
    irq_ack = 1'b1;
    int_req = 4'b0100;
    tick();
    irq_ack = 1'b0;
    int_req = '0;
    checks++;
    if (pending !== 4'b0100 || in_service !== 4'b0100 || irq_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_same_cycle: pend=%b ins=%b valid=%b want 0100/0100/0", pending, in_service, irq_valid);
    end
    exp_q.push_back(2'd2);
    pulse_eoi();
    next_irq(3, got, id, exp);
    checks++;
    if (!got || id !== exp) begin errors++; $display("[TB] FAIL b2b_repend: got %0d want %0d", id, exp); end
    pulse_ack();
    pulse_eoi();
    pulse_eoi();
    checks++;
    if (in_service !== 4'b0000 || pending !== 4'b0000 || irq_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL eoi_idle: ins=%b pend=%b valid=%b want 0000/0000/0", in_service, pending, irq_valid);
    end
  endtask

  task automatic test_nesting();
    bit got; logic [1:0] id, exp;
    int seen;
    exp_q.push_back(2'd2);
    pulse_req(4'b0100);
    next_irq(3, got, id, exp);
    checks++;
    if (!got || id !== exp) begin errors++; $display("[TB] FAIL nest_base: got %0d want %0d", id, exp); end
    pulse_ack();
`ifdef INT_CTRL_NESTING_EN
    exp_q.push_back(2'd0);
    pulse_req(4'b0001);
    next_irq(3, got, id, exp);
    checks++;
    if (!got || id !== exp) begin errors++; $display("[TB] FAIL nest_preempt: got %0d want %0d", id, exp); end
    irq_ack = 1'b1;
    irq_eoi = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_eoi = 1'b0;
    checks++;
    if (in_service !== 4'b0001) begin errors++; $display("[TB] FAIL nest_ack_eoi: got %b want 0001", in_service); end
    pulse_eoi();
    checks++;
    if (in_service !== 4'b0000) begin errors++; $display("[TB] FAIL nest_eoi: got %b want 0000", in_service); end
    exp_q.push_back(2'd0);
    pulse_req(4'b0100);
    next_irq(3, got, id, exp);
    checks++;
    if (!got || id !== 2'd2) begin errors++; $display("[TB] FAIL nest_redo: got %0d want 2", id); end
    pulse_ack();
    exp_q.delete();
    exp_q.push_back(2'd0);
    pulse_req(4'b0001);
    next_irq(3, got, id, exp);
    pulse_ack();
    checks++;
    if (in_service !== 4'b0101) begin errors++; $display("[TB] FAIL nest_two: got %b want 0101", in_service); end
    pulse_eoi();
    checks++;
    if (in_service !== 4'b0100) begin errors++; $display("[TB] FAIL nest_retire_top: got %b want 0100", in_service); end
    pulse_eoi();
`else
    pulse_req(4'b0001);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (irq_valid === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin errors++; $display("[TB] FAIL no_nest_block: valid cycles %0d want 0", seen); end
    exp_q.push_back(2'd0);
    pulse_eoi();
    checks++;
    if (irq_valid !== 1'b0 || in_service !== 4'b0000) begin
      errors++; $display("[TB] FAIL no_nest_eoi: valid=%b ins=%b want 0/0000", irq_valid, in_service);
    end
    next_irq(1, got, id, exp);
    checks++;
    if (!got || id !== exp) begin errors++; $display("[TB] FAIL no_nest_after: got %0d want %0d", id, exp); end
    pulse_ack();
    pulse_eoi();
`endif
    checks++;
    if (in_service !== 4'b0000) begin errors++; $display("[TB] FAIL nest_final: got %b want 0000", in_service); end
  endtask

  task automatic test_reset_mid();
    bit got; logic [1:0] id, exp;
    exp_q.push_back(2'd1);
    pulse_req(4'b1010);
    next_irq(3, got, id, exp);
    checks++;
    if (!got || id !== exp) begin errors++; $display("[TB] FAIL rst_pre: got %0d want %0d", id, exp); end
    rst = 1'b1;
    #1;
    checks++;
    if (irq_valid !== 1'b0 || irq_id !== 2'd0 || pending !== 4'b0000 || in_service !== 4'b0000) begin
      errors++; $display("[TB] FAIL rst_async: valid=%b id=%0d pend=%b ins=%b want all 0", irq_valid, irq_id, pending, in_service);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (irq_valid !== 1'b0 || pending !== 4'b0000) begin
      errors++; $display("[TB] FAIL rst_after: valid=%b pend=%b want 0/0000", irq_valid, pending);
    end
  endtask

  initial begin
    rst           = 1'b1;
    int_req       = '0;
    int_mask      = 4'b1111;
    global_int_en = 1'b1;
    irq_ack       = 1'b0;
    irq_eoi       = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_masking();
    test_back_to_back();
    test_nesting();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
